// File: rtl/minesweeper_control.sv
// Minesweeper game controller: owns the cursor and per-cell HIDDEN/FLAG/REVEALED state,
// queries the mine map at A and issues stallable single-cycle graphics-memory writes.
module minesweeper_control #(
  parameter int unsigned MINES = 40
) (
  input  logic       clk,
  input  logic       initcue,
  input  logic       mark_button,
  input  logic       tap_button,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       up_button,
  input  logic       down_button,
  input  logic [2:0] mine_cnt,
  input  logic       status,
  input  logic       valid,
  input  logic       transmit,
  output logic       dead,
  output logic [5:0] leftover,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [7:0] A,
  output logic       update,
  output logic [7:0] GMaddress,
  output logic [3:0] GMdata
);

  typedef enum logic [2:0] {S_CLEAR, S_WAIT, S_PLAY, S_EVAL, S_DEAD} state_e;
  typedef enum logic [1:0] {C_HIDDEN = 2'd0, C_FLAG = 2'd1, C_REVEALED = 2'd2} cell_e;

  localparam int B_TAP   = 5;
  localparam int B_MARK  = 4;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 2;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 0;

  state_e     state_q, state_d;
  logic [3:0] x_q, x_d, y_q, y_d;
  logic [5:0] left_q, left_d;
  logic       dead_q, dead_d;
  logic [7:0] clr_q, clr_d;
  logic       pend_q, pend_d;
  logic [7:0] gma_q, gma_d;
  logic [3:0] gmd_q, gmd_d;
  logic [5:0] btn_prev_q;
  logic [5:0] btn_now, btn_edge;

  logic [1:0] cell_q [256];
  logic       cell_we;
  logic [7:0] cell_wa;
  cell_e      cell_wd;
  cell_e      cur_cell;
  logic [7:0] cur_addr;
  logic       stall;

  assign btn_now  = {tap_button, mark_button, left_button, right_button, up_button, down_button};
  assign btn_edge = btn_now & ~btn_prev_q;
  assign cur_addr = {y_q, x_q};
  assign cur_cell = cell_e'(cell_q[cur_addr]);
  // A pending write that the display refuses freezes every other action.
  assign stall    = pend_q & transmit;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (initcue) begin
      state_q    <= S_CLEAR;
      x_q        <= '0;
      y_q        <= '0;
      left_q     <= 6'(MINES);
      dead_q     <= 1'b0;
      clr_q      <= '0;
      pend_q     <= 1'b0;
      gma_q      <= '0;
      gmd_q      <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      left_q     <= left_d;
      dead_q     <= dead_d;
      clr_q      <= clr_d;
      pend_q     <= pend_d;
      gma_q      <= gma_d;
      gmd_q      <= gmd_d;
      btn_prev_q <= btn_now;
    end
  end

  // NOTE: the cell array has no reset; the CLEAR sweep initialises every entry instead.
  always_ff @(posedge clk) begin
    if (cell_we) cell_q[cell_wa] <= cell_wd;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    dead_d  = dead_q;
    clr_d   = clr_q;
    pend_d  = pend_q & transmit;
    gma_d   = gma_q;
    gmd_d   = gmd_q;
    cell_we = 1'b0;
    cell_wa = cur_addr;
    cell_wd = C_HIDDEN;

    unique case (state_q)
      S_CLEAR: if (!stall) begin
        pend_d  = 1'b1;
        gma_d   = clr_q;
        gmd_d   = 4'd8;
        cell_we = 1'b1;
        cell_wa = clr_q;
        clr_d   = clr_q + 8'd1;
        if (clr_q == 8'd255) state_d = S_WAIT;
      end
      S_WAIT: if (valid) state_d = S_PLAY;
      S_PLAY: begin
        if (!valid) begin
          state_d = S_WAIT;
        end else if (!stall) begin
          if (btn_edge[B_TAP]) begin
            if (cur_cell == C_HIDDEN) state_d = S_EVAL;
          end else if (btn_edge[B_MARK]) begin
            if (cur_cell == C_HIDDEN) begin
              cell_we = 1'b1;
              cell_wd = C_FLAG;
              left_d  = (left_q == 6'd0) ? 6'd0 : left_q - 6'd1;
              pend_d  = 1'b1;
              gma_d   = cur_addr;
              gmd_d   = 4'd9;
            end else if (cur_cell == C_FLAG) begin
              cell_we = 1'b1;
              cell_wd = C_HIDDEN;
              left_d  = (left_q == 6'd63) ? 6'd63 : left_q + 6'd1;
              pend_d  = 1'b1;
              gma_d   = cur_addr;
              gmd_d   = 4'd8;
            end
          end else if (btn_edge[B_LEFT]) begin
            x_d = x_q - 4'd1;
          end else if (btn_edge[B_RIGHT]) begin
            x_d = x_q + 4'd1;
          end else if (btn_edge[B_UP]) begin
            y_d = y_q - 4'd1;
          end else if (btn_edge[B_DOWN]) begin
            y_d = y_q + 4'd1;
          end
        end
      end
      S_EVAL: if (!stall) begin
        pend_d = 1'b1;
        gma_d  = cur_addr;
        if (status) begin
          gmd_d   = 4'd10;
          dead_d  = 1'b1;
          state_d = S_DEAD;
        end else begin
          gmd_d   = {1'b0, mine_cnt};
          cell_we = 1'b1;
          cell_wd = C_REVEALED;
          state_d = S_PLAY;
        end
      end
      S_DEAD: ;
      default: state_d = S_CLEAR;
    endcase

    if (initcue) cell_we = 1'b0;
  end

  always_comb begin
    dead      = dead_q;
    leftover  = left_q;
    x         = x_q;
    y         = y_q;
    A         = cur_addr;
    update    = pend_q & ~transmit;
    GMaddress = gma_q;
    GMdata    = gmd_q;
  end

endmodule

// File: tb/tb_minesweeper_control.sv
// Scoreboard bench for minesweeper_control: a game-level model predicts writes and cursor/flag
// state from randomized button presses; a negedge monitor consumes every update strobe.
module tb_minesweeper_control;

  localparam int B_TAP = 0, B_MARK = 1, B_LEFT = 2, B_RIGHT = 3, B_UP = 4, B_DOWN = 5;

  logic       clk = 1'b0;
  logic       initcue = 1'b1;
  logic       mark_button = 1'b0, tap_button = 1'b0;
  logic       left_button = 1'b0, right_button = 1'b0, up_button = 1'b0, down_button = 1'b0;
  logic [2:0] mine_cnt;
  logic       status;
  logic       valid = 1'b1;
  logic       transmit = 1'b0;
  logic       dead;
  logic [5:0] leftover;
  logic [3:0] x, y;
  logic [7:0] A;
  logic       update;
  logic [7:0] GMaddress;
  logic [3:0] GMdata;

  minesweeper_control #(.MINES(40)) dut (
    .clk(clk), .initcue(initcue),
    .mark_button(mark_button), .tap_button(tap_button),
    .left_button(left_button), .right_button(right_button),
    .up_button(up_button), .down_button(down_button),
    .mine_cnt(mine_cnt), .status(status), .valid(valid), .transmit(transmit),
    .dead(dead), .leftover(leftover), .x(x), .y(y), .A(A),
    .update(update), .GMaddress(GMaddress), .GMdata(GMdata)
  );

  always #5 clk = ~clk;

  // External mine map
  bit         mine_map [256];
  logic [2:0] cnt_map  [256];
  always_comb begin
    status   = mine_map[A];
    mine_cnt = cnt_map[A];
  end

  typedef struct {
    logic [7:0] addr;
    logic [3:0] data;
  } wr_t;
  wr_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Game model: 0 hidden, 1 flagged, 2 revealed
  int m_cell [256];
  int m_x, m_y, m_left;
  bit m_dead, m_play;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (initcue == 1'b0 && update == 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_update: got addr %0h data %0h, required no write", GMaddress, GMdata);
      end else begin
        wr_t e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(GMaddress), 32'(e.addr));
        check("wr_data", 32'(GMdata), 32'(e.data));
        if (e.data == 4'd10) check("dead_with_boom_write", 32'(dead), 32'd1);
      end
    end
  end

  function automatic void push_wr(input int addr, input int data);
    wr_t e;
    e.addr = 8'(addr);
    e.data = 4'(data);
    sb_q.push_back(e);
  endfunction

  function automatic void model_apply(input int b);
    int a;
    a = m_y * 16 + m_x;
    if (!m_play || m_dead) return;
    case (b)
      B_TAP: if (m_cell[a] == 0) begin
        if (mine_map[a]) begin
          push_wr(a, 10);
          m_dead = 1'b1;
        end else begin
          push_wr(a, int'(cnt_map[a]));
          m_cell[a] = 2;
        end
      end
      B_MARK: if (m_cell[a] == 0) begin
        m_cell[a] = 1;
        m_left = (m_left > 0) ? m_left - 1 : 0;
        push_wr(a, 9);
      end else if (m_cell[a] == 1) begin
        m_cell[a] = 0;
        m_left = (m_left < 63) ? m_left + 1 : 63;
        push_wr(a, 8);
      end
      B_LEFT:  m_x = (m_x + 15) % 16;
      B_RIGHT: m_x = (m_x + 1) % 16;
      B_UP:    m_y = (m_y + 15) % 16;
      default: m_y = (m_y + 1) % 16;
    endcase
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_TAP:   tap_button   = v;
      B_MARK:  mark_button  = v;
      B_LEFT:  left_button  = v;
      B_RIGHT: right_button = v;
      B_UP:    up_button    = v;
      default: down_button  = v;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_x"}, 32'(x), 32'(m_x));
    check({tag, "_y"}, 32'(y), 32'(m_y));
    check({tag, "_A"}, 32'(A), 32'(m_y * 16 + m_x));
    check({tag, "_leftover"}, 32'(leftover), 32'(m_left));
    check({tag, "_dead"}, 32'(dead), 32'(m_dead));
  endtask

  task automatic press(input int b, input int stall_cycles);
    model_apply(b);
    @(posedge clk); #1 set_btn(b, 1'b1);
    @(posedge clk); #1 set_btn(b, 1'b0);
    if (stall_cycles > 0) begin
      transmit = 1'b1;
      repeat (stall_cycles) @(posedge clk);
      #1 transmit = 1'b0;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_state("press");
  endtask

  task automatic goto_cell(input int tx, input int ty);
    for (int g = 0; g < 16 && m_x != tx; g++) press(B_RIGHT, 0);
    for (int g = 0; g < 16 && m_y != ty; g++) press(B_DOWN, 0);
  endtask

  task automatic start_clear();
    @(posedge clk); #1 initcue = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_dead", 32'(dead), 32'd0);
    check("rst_leftover", 32'(leftover), 32'd40);
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_A", 32'(A), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_GMaddress", 32'(GMaddress), 32'd0);
    check("rst_GMdata", 32'(GMdata), 32'd0);
    for (int i = 0; i < 256; i++) m_cell[i] = 0;
    m_x = 0; m_y = 0; m_left = 40; m_dead = 1'b0; m_play = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 256; i++) push_wr(i, 8);
    @(posedge clk); #1 initcue = 1'b0;
  endtask

  task automatic finish_clear();
    repeat (256) @(posedge clk);
    @(negedge clk);
    #1 check("clear_256_consecutive", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    m_play = valid;
    @(negedge clk);
    check_state("after_clear");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, b;
    logic [3:0] exp_d;

    for (int i = 0; i < 256; i++) begin
      mine_map[i] = 1'b0;
      cnt_map[i]  = 3'($urandom_range(0, 7));
    end
    mine_map[8'h01] = 1'b1;
    cnt_map[8'h52]  = 3'd3;

    start_clear();
    finish_clear();

    // Cursor wrap in x
    for (int i = 0; i < 16; i++) press(B_RIGHT, 0);
    press(B_LEFT, 0);
    check("left_wrap_x", 32'(x), 32'd15);
    check("left_wrap_A", 32'(A), 32'h0f);

    // Safe reveal at (2,5), then a repeated tap that must not write
    goto_cell(2, 5);
    press(B_TAP, 0);
    press(B_TAP, 0);

    // Flag toggling and a tap on a flagged cell
    press(B_RIGHT, 0);
    press(B_MARK, 0);
    check("mark_leftover_39", 32'(leftover), 32'd39);
    press(B_MARK, 0);
    check("unmark_leftover_40", 32'(leftover), 32'd40);
    press(B_MARK, 0);
    press(B_TAP, 0);
    press(B_MARK, 0);

    // Tap write held by transmit
    goto_cell(7, 7);
    exp_d = {1'b0, cnt_map[8'h77]};
    transmit = 1'b1;
    model_apply(B_TAP);
    @(posedge clk); #1 tap_button = 1'b1;
    @(posedge clk); #1 tap_button = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("stall_update_low", 32'(update), 32'd0);
    check("stall_addr_held", 32'(GMaddress), 32'h77);
    check("stall_data_held", 32'(GMdata), 32'(exp_d));
    @(posedge clk); #1 transmit = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_single_pulse", 32'(sb_q.size()), 32'd0);

    // Loss of valid parks the controller in WAIT; cursor is kept
    valid = 1'b0;
    repeat (3) @(posedge clk);
    m_play = 1'b0;
    press(B_RIGHT, 0);
    valid = 1'b1;
    repeat (3) @(posedge clk);
    m_play = 1'b1;
    press(B_RIGHT, 0);

    // Mine at (1,0); everything after is ignored
    goto_cell(1, 0);
    press(B_TAP, 0);
    check("dead_after_mine", 32'(dead), 32'd1);
    press(B_TAP, 0);
    press(B_LEFT, 0);
    press(B_DOWN, 0);
    press(B_MARK, 0);
    check("dead_cursor_frozen_A", 32'(A), 32'h01);

    // Restart from DEAD, then restart again in the middle of CLEAR
    for (int i = 0; i < 256; i++) begin
      mine_map[i] = ($urandom_range(0, 99) < 10);
      cnt_map[i]  = 3'($urandom_range(0, 7));
    end
    start_clear();
    repeat (100) @(posedge clk);
    start_clear();
    finish_clear();

    // Randomized play with occasional display stalls
    for (int n = 0; n < 250; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 15)      b = B_TAP;
      else if (r < 30) b = B_MARK;
      else             b = B_LEFT + (r % 4);
      press(b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("final_scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
